// File: rtl/fl_fifo_frame_arbiter.sv
// Frame-granular round-robin arbiter merging PORTS FrameLink FIFO read sides onto one FL TX bus.
// Define FL_FRAME_ARB_STATS_EN to add FRAME_CNT / STALL_CNT statistics outputs.
module fl_fifo_frame_arbiter #(
   parameter int PORTS      = 4,
   parameter int DATA_WIDTH = 64,
   parameter int REM_WIDTH  = 3
) (
   input  logic                        CLK,
   input  logic                        RESET,
   input  logic [PORTS*DATA_WIDTH-1:0] RX_DATA,
   input  logic [PORTS*REM_WIDTH-1:0]  RX_REM,
   input  logic [PORTS-1:0]            RX_SOF_N,
   input  logic [PORTS-1:0]            RX_EOF_N,
   input  logic [PORTS-1:0]            RX_SOP_N,
   input  logic [PORTS-1:0]            RX_EOP_N,
   input  logic [PORTS-1:0]            RX_SRC_RDY_N,
   output logic [PORTS-1:0]            RX_DST_RDY_N,
   input  logic [PORTS-1:0]            FIFO_FRAME_RDY,
   output logic [DATA_WIDTH-1:0]       TX_DATA,
   output logic [REM_WIDTH-1:0]        TX_REM,
   output logic                        TX_SOF_N,
   output logic                        TX_EOF_N,
   output logic                        TX_SOP_N,
   output logic                        TX_EOP_N,
   output logic                        TX_SRC_RDY_N,
   input  logic                        TX_DST_RDY_N,
   output logic [PORTS-1:0]            GRANT
`ifdef FL_FRAME_ARB_STATS_EN
   ,
   output logic [32*PORTS-1:0]         FRAME_CNT,
   output logic [31:0]                 STALL_CNT
`endif
);

   localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;

   typedef enum logic {IDLE, XFER} state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
   logic [IDX_W-1:0] gidx, gidx_nxt;
   logic [IDX_W-1:0] pick, cand;
   logic [PORTS-1:0] grant_nxt;
   logic             found;
   logic             xfer;
   logic             eof_xfer;

   // First FRAME_RDY requester at or after rr_ptr, wrapping modulo PORTS.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int unsigned k = 0; k < PORTS; k++) begin
         cand = IDX_W'((32'(rr_ptr) + k) % PORTS);
         if (!found && FIFO_FRAME_RDY[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      rr_ptr_nxt   = rr_ptr;
      gidx_nxt     = gidx;
      grant_nxt    = GRANT;
      TX_DATA      = '0;
      TX_REM       = '0;
      TX_SOF_N     = 1'b1;
      TX_EOF_N     = 1'b1;
      TX_SOP_N     = 1'b1;
      TX_EOP_N     = 1'b1;
      TX_SRC_RDY_N = 1'b1;
      RX_DST_RDY_N = '1;
      xfer         = 1'b0;
      eof_xfer     = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt = XFER;
               gidx_nxt  = pick;
               grant_nxt = {{(PORTS-1){1'b0}}, 1'b1} << pick;
            end
         end
         XFER: begin
            TX_DATA            = RX_DATA[gidx*DATA_WIDTH +: DATA_WIDTH];
            TX_REM             = RX_REM[gidx*REM_WIDTH +: REM_WIDTH];
            TX_SOF_N           = RX_SOF_N[gidx];
            TX_EOF_N           = RX_EOF_N[gidx];
            TX_SOP_N           = RX_SOP_N[gidx];
            TX_EOP_N           = RX_EOP_N[gidx];
            TX_SRC_RDY_N       = RX_SRC_RDY_N[gidx];
            RX_DST_RDY_N[gidx] = TX_DST_RDY_N;
            xfer               = !RX_SRC_RDY_N[gidx] && !TX_DST_RDY_N;
            eof_xfer           = xfer && !RX_EOF_N[gidx];
            if (eof_xfer) begin
               state_nxt  = IDLE;
               grant_nxt  = '0;
               rr_ptr_nxt = IDX_W'((32'(gidx) + 1) % PORTS);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state  <= IDLE;
         rr_ptr <= '0;
         gidx   <= '0;
         GRANT  <= '0;
      end else begin
         state  <= state_nxt;
         rr_ptr <= rr_ptr_nxt;
         gidx   <= gidx_nxt;
         GRANT  <= grant_nxt;
      end
   end

`ifdef FL_FRAME_ARB_STATS_EN
   // Frame counters wrap; the stall counter saturates.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         FRAME_CNT <= '0;
         STALL_CNT <= '0;
      end else begin
         if (eof_xfer)
            FRAME_CNT[gidx*32 +: 32] <= FRAME_CNT[gidx*32 +: 32] + 32'd1;
         if (state == XFER && !TX_SRC_RDY_N && TX_DST_RDY_N && STALL_CNT != '1)
            STALL_CNT <= STALL_CNT + 32'd1;
      end
   end
`endif

endmodule
